// File: rtl/out_port_uart_pkg.sv
// Shared types and helpers for the OUT-A serial output port.
package out_port_uart_pkg;

  localparam int BYTE_W = 8;

  // Transmitter state codes. The encoding is fixed so the codes can be
  // matched against the shared OUT_* state constants used elsewhere.
  typedef enum logic [1:0] {
    OUT_IDLE  = 2'd0,
    OUT_START = 2'd1,
    OUT_DATA  = 2'd2,
    OUT_STOP  = 2'd3
  } tx_state_t;

  // Returns the width of a counter that runs from 0 to clks-1. The width
  // is never allowed to drop to zero, even when clks is 1.
  function automatic int baud_w(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/out_port_uart_byte_fifo.sv
// Small byte FIFO with occupancy count. A write while the FIFO is full is
// ignored. A read while it is empty is ignored. The head entry is always
// visible on rd_data.
module byte_fifo
  import out_port_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [BYTE_W-1:0]       wr_data,
  input  logic                    rd_en,
  output logic [BYTE_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // Full and empty come from the pre-edge count. A same-cycle read
  // therefore never makes room for a same-cycle write.
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write. The contents need no reset because the count guards them.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/out_port_uart.sv
// OUT-A output stage. It captures bus bytes on c_oi into a FIFO and sends
// them as 8N1 frames on tx, LSB first. It stalls the CPU while the FIFO is full.
//
// Handshake: a byte is taken on a rising clk edge when c_oi=1 and stall=0,
// with stall sampled before that edge. c_oi=1 while stall=1 drops the byte
// and sets the sticky overflow flag. The CPU holds its state instead of
// strobing c_oi again.
module out_port_uart
  import out_port_uart_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BYTE_W-1:0]       bus,
  input  logic                    c_oi,
  output logic                    stall,
  output logic                    tx,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int BW = baud_w(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] head;
  logic              push;
  logic              pop;

  tx_state_t         state,    state_n;
  logic [BW-1:0]     baud_cnt, baud_n;
  logic [2:0]        bit_idx,  bit_n;
  logic [BYTE_W-1:0] shift,    shift_n;
  logic              tx_q,     tx_n;

  assign push  = c_oi && !fifo_full;
  assign stall = fifo_full;
  assign busy  = (state != OUT_IDLE);
  assign tx    = tx_q;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (bus),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sticky drop flag. Only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (c_oi && fifo_full) overflow <= 1'b1;
  end

  // Transmitter register bank. On reset, tx goes high at once, which
  // aborts any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= OUT_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      tx_q     <= tx_n;
    end
  end

  // Transmitter next-state logic. tx_n is the line level for the next
  // state, so the line changes on the same edge as the state or bit.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state)
      OUT_IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = head;
          baud_n  = '0;
          state_n = OUT_START;
          tx_n    = 1'b0;
        end
      end
      OUT_START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = OUT_DATA;
          tx_n    = shift[0];
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      OUT_DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = OUT_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + 1'b1;
            shift_n = {1'b0, shift[BYTE_W-1:1]};
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      OUT_STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          state_n = OUT_IDLE;
          tx_n    = 1'b1;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = OUT_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_out_port_uart.sv
// Bench for out_port_uart (DEPTH=4, CLKS_PER_BIT=4). A serial monitor
// decodes frames from tx and pops the expected bytes from exp_q.
module tb_out_port_uart;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus;
  logic       c_oi;
  logic       stall;
  logic       tx;
  logic       busy;
  logic [2:0] count;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         start_cyc[$];

  typedef struct {
    logic [7:0] bus;
    logic       c_oi;
    logic       accept;
    logic [2:0] count;
    logic       stall;
    logic       ovf;
    logic       busy;
  } vec_t;

  out_port_uart #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .c_oi     (c_oi),
    .stall    (stall),
    .tx       (tx),
    .busy     (busy),
    .count    (count),
    .overflow (overflow)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait until every expected frame has been seen and the port is idle and empty.
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0 || count !== 3'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", (n < budget), 1);
  endtask

  // Serial monitor: finds a start edge, samples each bit mid-cell, checks
  // the framing bits and compares the byte with the scoreboard.
  initial begin : monitor
    logic       prev;
    logic       aborted;
    logic [7:0] data;
    logic [7:0] want;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && tx === 1'b0) begin
        start_cyc.push_back(cyc);
        aborted = 1'b0;
        data    = '0;
        for (int j = 1; j <= 38; j++) begin
          @(negedge clk);
          if (reset === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (j == 2) check("start_bit", tx, 0);
          if (j >= 6 && j <= 34 && ((j - 6) % 4) == 0) data[(j - 6) / 4] = tx;
          if (j == 38) check("stop_bit", tx, 1);
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_byte: got %0h, expected no frame (cycle %0d)", data, cyc);
          end else begin
            want = exp_q.pop_front();
            check("frame_byte", data, want);
          end
        end
        prev = 1'b1;
      end else begin
        prev = tx;
      end
    end
  end

  // Stimulus
  initial begin : main
    vec_t       vecs[7];
    logic [9:0] a5_frame;
    int         n;

    // Line levels for 8'hA5, first bit sent in bit 0: start, LSB..MSB, stop
    a5_frame = 10'b1101001010;

    // Fill and overflow sequence with the transmitter idle at the start
    vecs[0] = '{8'h01, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h04, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h05, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1};

    // Reset state, checked before any clock edge
    reset = 1'b1;
    c_oi  = 1'b0;
    bus   = 8'h00;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_stall", stall, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single byte 8'hA5: latency and the timing of each bit
    bus  = 8'hA5;
    c_oi = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    c_oi = 1'b0;
    check("a5_count_n", count, 1);
    check("a5_busy_n", busy, 0);
    check("a5_tx_n", tx, 1);
    @(negedge clk);
    check("a5_count_pop", count, 0);
    for (int j = 0; j < FRAME; j++) begin
      check("a5_tx_bit", tx, a5_frame[j / CPB]);
      check("a5_busy", busy, 1);
      @(negedge clk);
    end
    check("a5_tx_idle", tx, 1);
    check("a5_busy_end", busy, 0);
    wait_drain(200);

    // Table-driven fill and overflow
    for (int i = 0; i < 7; i++) begin
      bus  = vecs[i].bus;
      c_oi = vecs[i].c_oi;
      if (vecs[i].accept) exp_q.push_back(vecs[i].bus);
      @(negedge clk);
      check("fill_count", count, vecs[i].count);
      check("fill_stall", stall, vecs[i].stall);
      check("fill_overflow", overflow, vecs[i].ovf);
      check("fill_busy", busy, vecs[i].busy);
    end
    c_oi = 1'b0;
    repeat (20) @(negedge clk);
    check("full_count_held", count, 4);
    check("full_stall_held", stall, 1);
    wait_drain(600);
    check("overflow_sticky", overflow, 1);
    check("drained_stall", stall, 0);

    // Reset during DATA bit 3 takes effect without a clock edge
    bus  = 8'h00;
    c_oi = 1'b1;
    @(negedge clk);
    c_oi = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 1);
    repeat (17) @(negedge clk);
    check("mid_tx_bit3", tx, 0);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_tx", tx, 1);

    // Push and pop on the same edge, plus back-to-back frame spacing
    start_cyc.delete();
    bus  = 8'h11;
    c_oi = 1'b1;
    exp_q.push_back(8'h11);
    @(negedge clk);
    bus = 8'h22;
    exp_q.push_back(8'h22);
    @(negedge clk);
    bus = 8'h33;
    exp_q.push_back(8'h33);
    @(negedge clk);
    c_oi = 1'b0;
    check("pp_count_pre", count, 2);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pp_idle_in_budget", (n < 100), 1);
    check("pp_count_idle", count, 2);
    bus  = 8'h3C;
    c_oi = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge clk);
    c_oi = 1'b0;
    check("pp_count_same", count, 2);
    check("pp_busy", busy, 1);
    wait_drain(1000);
    check("b2b_frames", start_cyc.size(), 4);
    if (start_cyc.size() >= 4) begin
      for (int k = 1; k < 4; k++) check("b2b_gap", start_cyc[k] - start_cyc[k - 1], FRAME + 1);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
